// File: rtl/mul_rr_arbiter.sv
// Two-requester arbiter in front of one iterative rv32 multiplier; latches the winner's
// operands, runs the mul handshake and returns the result with a one-cycle ready pulse.
// Build option: MUL_ARB_FIXED_PRIO_EN gives requester 0 absolute priority (default: round-robin).
module mul_rr_arbiter #(
  parameter int OP_W = 3,
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            req0_valid,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,
  input  logic [OP_W-1:0] req0_op,
  output logic            req0_ready,
  output logic [XLEN-1:0] req0_result,
  input  logic            req1_valid,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,
  input  logic [OP_W-1:0] req1_op,
  output logic            req1_ready,
  output logic [XLEN-1:0] req1_result,
  output logic            mul_valid,
  output logic [XLEN-1:0] mul_a,
  output logic [XLEN-1:0] mul_b,
  output logic [OP_W-1:0] mul_op,
  input  logic            mul_ready,
  input  logic [XLEN-1:0] mul_result,
  output logic            busy
);

  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_BUSY = 3'b010,
    S_DONE = 3'b100
  } state_t;

  state_t          r_state;
  logic            r_grant;
  logic            r_req0_ready, r_req1_ready;
  logic [XLEN-1:0] r_req0_result, r_req1_result;
  logic            r_mul_valid;
  logic [XLEN-1:0] r_mul_a, r_mul_b;
  logic [OP_W-1:0] r_mul_op;
  logic            r_busy;
  logic            w_any;
  logic            w_win;
`ifndef MUL_ARB_FIXED_PRIO_EN
  logic            r_last_grant;
`endif

  assign w_any = req0_valid | req1_valid;

  // w_win is the index of the requester granted this cycle (only used when w_any)
  always_comb begin
`ifdef MUL_ARB_FIXED_PRIO_EN
    w_win = ~req0_valid;
`else
    if (req0_valid && req1_valid) w_win = ~r_last_grant;
    else                          w_win = ~req0_valid;
`endif
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state       <= S_IDLE;
      r_grant       <= 1'b0;
      r_req0_ready  <= 1'b0;
      r_req1_ready  <= 1'b0;
      r_req0_result <= '0;
      r_req1_result <= '0;
      r_mul_valid   <= 1'b0;
      r_mul_a       <= '0;
      r_mul_b       <= '0;
      r_mul_op      <= '0;
      r_busy        <= 1'b0;
`ifndef MUL_ARB_FIXED_PRIO_EN
      r_last_grant  <= 1'b1;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_mul_a      <= w_win ? req1_a  : req0_a;
            r_mul_b      <= w_win ? req1_b  : req0_b;
            r_mul_op     <= w_win ? req1_op : req0_op;
            r_mul_valid  <= 1'b1;
            r_grant      <= w_win;
`ifndef MUL_ARB_FIXED_PRIO_EN
            r_last_grant <= w_win;
`endif
            r_busy       <= 1'b1;
            r_state      <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (mul_ready) begin
            r_mul_valid <= 1'b0;
            if (r_grant) begin
              r_req1_result <= mul_result;
              r_req1_ready  <= 1'b1;
            end else begin
              r_req0_result <= mul_result;
              r_req0_ready  <= 1'b1;
            end
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          // one dead cycle so the winner can drop valid before re-arbitration
          r_req0_ready <= 1'b0;
          r_req1_ready <= 1'b0;
          r_busy       <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req0_ready  = r_req0_ready;
  assign req1_ready  = r_req1_ready;
  assign req0_result = r_req0_result;
  assign req1_result = r_req1_result;
  assign mul_valid   = r_mul_valid;
  assign mul_a       = r_mul_a;
  assign mul_b       = r_mul_b;
  assign mul_op      = r_mul_op;
  assign busy        = r_busy;

endmodule
